// File: rtl/psimd_pkg.sv
// Shared types and sizes for the PSIMD writeback gather path.
package psimd_pkg;

  localparam int LANES     = 4;
  localparam int FP_W      = 16;
  localparam int INT_W     = 32;
  localparam int REG_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT0   = 2'd2,
    EMIT1   = 2'd3
  } pack_state_t;

  typedef enum logic {
    MODE_FP16  = 1'b0,
    MODE_INT32 = 1'b1
  } lane_mode_t;

  function automatic logic is_emit(input pack_state_t s);
    return (s == EMIT0) || (s == EMIT1);
  endfunction

endpackage

// File: rtl/lane_capture_reg.sv
// One lane's result holder: captures the first strobe of an instruction and
// flags any repeat strobe while the got bit is already set.
module lane_capture_reg
  import psimd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             cap_en_i,
  input  logic             valid_i,
  input  lane_mode_t       mode_i,
  input  logic [FP_W-1:0]  fp_i,
  input  logic [INT_W-1:0] int_i,
  output logic [INT_W-1:0] data_o,
  output logic             got_nxt_o,
  output logic             dup_o
);

  logic [INT_W-1:0] data_q, data_d;
  logic             got_q, got_d;
  logic             got_base;

  // Clear happens in the same cycle as a capture, so capture sees the cleared mask.
  always_comb begin
    got_base = clr_i ? 1'b0 : got_q;
    data_d   = clr_i ? {INT_W{1'b0}} : data_q;
    got_d    = got_base;
    dup_o    = 1'b0;
    if (cap_en_i && valid_i) begin
      if (got_base) begin
        dup_o = 1'b1;
      end else begin
        got_d  = 1'b1;
        data_d = (mode_i == MODE_INT32) ? int_i : {{(INT_W-FP_W){1'b0}}, fp_i};
      end
    end else begin
      dup_o = 1'b0;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= {INT_W{1'b0}};
      got_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      got_q  <= got_d;
    end
  end

  assign data_o    = data_q;
  assign got_nxt_o = got_d;

endmodule

// File: rtl/lane_packer.sv
// Gathers per-lane results into 64-bit register words and hands them to
// writeback over valid/ready; int32 instructions produce two words.
module lane_packer
  import psimd_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   mode_i,
  input  logic [LANES-1:0]       lane_valid_i,
  input  logic [LANES*FP_W-1:0]  fp_lane_i,
  input  logic [LANES*INT_W-1:0] int_lane_i,
  output logic                   busy_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [REG_WIDTH-1:0]   out_data_o,
  output logic                   out_idx_o,
  output logic                   out_last_o,
  output logic                   err_o
);

  pack_state_t          state_q, state_d;
  lane_mode_t           mode_q, mode_d, cap_mode;
  logic [LANES-1:0]     got_nxt, dup;
  logic [INT_W-1:0]     lane_data [LANES];
  logic                 start_take, cap_en, xfer, all_done;
  logic                 busy_q, busy_d, valid_q, valid_d, idx_q, idx_d;
  logic                 last_q, last_d, err_q, err_d;
  logic [REG_WIDTH-1:0] data_q, data_d;

  assign start_take = (state_q == IDLE) && start_i;
  assign cap_en     = start_take || (state_q == COLLECT);
  assign cap_mode   = start_take ? lane_mode_t'(mode_i) : mode_q;
  assign xfer       = valid_q && out_ready_i;
  assign all_done   = &got_nxt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_capture_reg u_cap (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (start_take),
      .cap_en_i  (cap_en),
      .valid_i   (lane_valid_i[i]),
      .mode_i    (cap_mode),
      .fp_i      (fp_lane_i[FP_W*i +: FP_W]),
      .int_i     (int_lane_i[INT_W*i +: INT_W]),
      .data_o    (lane_data[i]),
      .got_nxt_o (got_nxt[i]),
      .dup_o     (dup[i])
    );
  end

  // Next state, mode latch and protocol-violation detection.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = !start_i && (|lane_valid_i);
        if (start_i) begin
          mode_d  = lane_mode_t'(mode_i);
          state_d = all_done ? EMIT0 : COLLECT;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        err_d   = |dup;
        state_d = all_done ? EMIT0 : COLLECT;
      end
      EMIT0: begin
        err_d = |lane_valid_i;
        if (xfer) begin
          state_d = (mode_q == MODE_INT32) ? EMIT1 : IDLE;
        end else begin
          state_d = EMIT0;
        end
      end
      EMIT1: begin
        err_d   = |lane_valid_i;
        state_d = xfer ? IDLE : EMIT1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs lag entry into EMIT0 by one cycle and follow the post-handshake state.
  always_comb begin
    busy_d  = (state_d != IDLE);
    valid_d = 1'b0;
    idx_d   = 1'b0;
    last_d  = 1'b0;
    data_d  = {REG_WIDTH{1'b0}};
    if (is_emit(state_q) && is_emit(state_d)) begin
      valid_d = 1'b1;
      if (state_d == EMIT1) begin
        data_d = {lane_data[3], lane_data[2]};
        idx_d  = 1'b1;
        last_d = 1'b1;
      end else if (mode_q == MODE_INT32) begin
        data_d = {lane_data[1], lane_data[0]};
      end else begin
        data_d = {lane_data[3][FP_W-1:0], lane_data[2][FP_W-1:0],
                  lane_data[1][FP_W-1:0], lane_data[0][FP_W-1:0]};
        last_d = 1'b1;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_FP16;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= {REG_WIDTH{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign busy_o      = busy_q;
  assign out_valid_o = valid_q;
  assign out_idx_o   = idx_q;
  assign out_last_o  = last_q;
  assign out_data_o  = data_q;
  assign err_o       = err_q;

endmodule
